// File: rtl/r200_pkg.sv
// Shared fetch-stage definitions: widths, default reset PC, sequential step and PC adder.
package r200_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned PC_STEP  = 4;

    typedef logic [XLEN-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    function automatic logic [31:0] adder32(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/r200fq.sv
// DEPTH-entry circular prefetch queue with flush; occupancy kept in a separate counter.
module r200fq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic [WIDTH-1:0]           head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data;
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign head_data = mem[rd_ptr_q];

endmodule

// File: rtl/r200ifq.sv
// Instruction-fetch stage: owns the PC, prefetches into r200fq, hands instructions to decode.
module r200ifq #(
    parameter int unsigned     XLEN     = r200_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = r200_pkg::RESET_PC,
    parameter int unsigned     PC_STEP  = r200_pkg::PC_STEP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       br_valid,
    input  logic [XLEN-1:0]            br_targ,
    input  logic                       jmp_valid,
    input  logic [XLEN-1:0]            jmp_targ,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);

    import r200_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = INSTR_W + XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q;
    logic            redirect;
    logic [XLEN-1:0] redir_sel;
    logic [XLEN-1:0] redir_targ;
    logic [CW:0]     occupancy;
    logic            push, pop, fq_empty;
    logic [EW-1:0]   head_data;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    // Branch resolves in EX and is older than a jump from ID, so it wins.
    assign redirect   = br_valid | jmp_valid;
    assign redir_sel  = br_valid ? br_targ : jmp_targ;
    assign redir_targ = {redir_sel[XLEN-1:2], 2'b00};

    // Credit uses registered count only; a same-cycle pop is not counted as a free slot.
    assign occupancy = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q};
    assign imem_req  = rst_n && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    // Memory latency is one cycle, so killing the outstanding fetch reduces to
    // dropping its return in the redirect cycle itself.
    assign push = inflight_q && !redirect;

    assign out_valid = !fq_empty && !redirect;
    assign pop       = out_valid && out_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redir_targ;
        end else if (imem_req) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_req;
        end
    end

    r200fq #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, pc_q - XLEN'(PC_STEP)}),
        .pop       (pop),
        .flush     (redirect),
        .count     (fq_count),
        .empty     (fq_empty),
        .head_data (head_data)
    );

    assign head_pc    = head_data[XLEN-1:0];
    assign head_instr = head_data[EW-1:XLEN];

    // Head fields read as zero while the queue is empty, including throughout reset.
    assign out_instr = fq_empty ? '0 : head_instr;
    assign out_pc    = fq_empty ? '0 : head_pc;
    assign out_pcp4  = fq_empty ? '0 : XLEN'(adder32(32'(head_pc), 32'(PC_STEP)));

endmodule

// File: tb/tb_r200ifq.sv
// Directed bench for r200ifq: default instance plus a wrap-around RESET_PC instance.
module tb_r200ifq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_valid, jmp_valid;
    logic [31:0] br_targ, jmp_targ;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pcp4;
    logic [2:0]  fq_count;

    logic        w_req;
    logic [31:0] w_addr, w_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr, w_out_pc, w_out_pcp4;
    logic [2:0]  w_fq_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
        if (w_req)    w_rdata    <= w_addr ^ 32'hA5A5_0000;
    end

    r200ifq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_valid   (br_valid),
        .br_targ    (br_targ),
        .jmp_valid  (jmp_valid),
        .jmp_targ   (jmp_targ),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pcp4   (out_pcp4),
        .fq_count   (fq_count)
    );

    r200ifq #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_rdata (w_rdata),
        .br_valid   (1'b0),
        .br_targ    (32'h0),
        .jmp_valid  (1'b0),
        .jmp_targ   (32'h0),
        .out_valid  (w_out_valid),
        .out_ready  (1'b1),
        .out_instr  (w_out_instr),
        .out_pc     (w_out_pc),
        .out_pcp4   (w_out_pcp4),
        .fq_count   (w_fq_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        br_valid   = 1'b0;
        jmp_valid  = 1'b0;
        br_targ    = '0;
        jmp_targ   = '0;
        imem_rdata = '0;
        w_rdata    = '0;
        tick();
        tick();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_count", 32'(fq_count),  32'd0);
        chk("rst_pc",    out_pc,         32'd0);
        chk("rst_instr", out_instr,      32'd0);

        // Cycle 0: reset released.
        tick();
        rst_n = 1'b1;
        #1;
        chk("c0_req",   32'(imem_req), 32'd1);
        chk("c0_addr",  imem_addr,     32'h0);
        chk("c0_waddr", w_addr,        32'hFFFF_FFF8);
        tick(); #1;
        chk("c1_valid", 32'(out_valid), 32'd0);
        chk("c1_addr",  imem_addr,      32'h4);
        tick(); #1;
        chk("c2_valid", 32'(out_valid), 32'd1);
        chk("c2_pc",    out_pc,         32'h0);
        chk("c2_instr", out_instr,      32'hA5A5_0000);
        chk("c2_pcp4",  out_pcp4,       32'h4);
        chk("c2_wpc",   w_out_pc,       32'hFFFF_FFF8);
        tick(); #1;
        chk("c3_pc",    out_pc,     32'h4);
        chk("c3_pcp4",  out_pcp4,   32'h8);
        chk("c3_wpc",   w_out_pc,   32'hFFFF_FFFC);
        chk("c3_wpcp4", w_out_pcp4, 32'h0);
        tick(); #1;
        chk("c4_pc",    out_pc,      32'h8);
        chk("c4_wpc",   w_out_pc,    32'h0);
        chk("c4_winstr", w_out_instr, 32'hA5A5_0000);
        tick(); #1;
        chk("c5_pc",    out_pc,    32'hC);
        chk("c5_instr", out_instr, 32'hA5A5_000C);

        // Stall decode for 10 cycles (6..15).
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 7; i <= 15; i++) tick();
        #1;
        chk("stall_count", 32'(fq_count),  32'd4);
        chk("stall_req",   32'(imem_req),  32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc",    out_pc,         32'h10);

        // Cycles 16..21: drain with no lost or duplicated PC.
        for (int k = 0; k < 6; k++) begin
            tick();
            out_ready = 1'b1;
            #1;
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc",    out_pc,         32'h10 + 32'(4 * k));
        end

        // Cycle 22: build three queued entries plus one in flight.
        tick();
        out_ready = 1'b0;
        #1;
        chk("c22_pc",    out_pc,         32'h28);
        chk("c22_count", 32'(fq_count),  32'd2);
        chk("c22_addr",  imem_addr,      32'h34);

        // Cycle 23 (T): jump.
        tick();
        jmp_valid = 1'b1;
        jmp_targ  = 32'h100;
        #1;
        chk("jmp_count", 32'(fq_count),  32'd3);
        chk("jmp_req",   32'(imem_req),  32'd0);
        chk("jmp_valid", 32'(out_valid), 32'd0);
        tick();
        jmp_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("jmp1_count", 32'(fq_count),  32'd0);
        chk("jmp1_req",   32'(imem_req),  32'd1);
        chk("jmp1_addr",  imem_addr,      32'h100);
        chk("jmp1_valid", 32'(out_valid), 32'd0);
        tick(); #1;
        chk("jmp2_valid", 32'(out_valid), 32'd0);
        chk("jmp2_addr",  imem_addr,      32'h104);
        tick(); #1;
        chk("jmp3_valid", 32'(out_valid), 32'd1);
        chk("jmp3_pc",    out_pc,         32'h100);
        chk("jmp3_instr", out_instr,      32'hA5A5_0100);
        tick(); #1;
        chk("jmp4_pc", out_pc, 32'h104);

        // Cycle 28: branch and jump together; branch wins.
        tick();
        br_valid  = 1'b1;
        br_targ   = 32'h200;
        jmp_valid = 1'b1;
        jmp_targ  = 32'h300;
        #1;
        chk("bj_req",   32'(imem_req),  32'd0);
        chk("bj_valid", 32'(out_valid), 32'd0);
        tick();
        br_valid  = 1'b0;
        jmp_valid = 1'b0;
        #1;
        chk("bj1_addr", imem_addr, 32'h200);
        tick();
        tick(); #1;
        chk("bj3_pc",   out_pc,   32'h200);
        chk("bj3_pcp4", out_pcp4, 32'h204);
        tick(); #1;
        chk("bj4_pc", out_pc, 32'h204);

        // Misaligned jump target is forced to a word boundary.
        tick();
        jmp_valid = 1'b1;
        jmp_targ  = 32'h103;
        #1;
        tick();
        jmp_valid = 1'b0;
        #1;
        chk("align_addr", imem_addr, 32'h100);
        tick();
        tick(); #1;
        chk("align_pc", out_pc, 32'h100);

        // Asynchronous reset mid-stream with a fetch outstanding.
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_req",   32'(imem_req),  32'd0);
        chk("arst_count", 32'(fq_count),  32'd0);
        chk("arst_pc",    out_pc,         32'h0);
        chk("arst_instr", out_instr,      32'h0);
        chk("arst_pcp4",  out_pcp4,       32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel0_req",  32'(imem_req), 32'd1);
        chk("rel0_addr", imem_addr,     32'h0);
        tick(); #1;
        chk("rel1_valid", 32'(out_valid), 32'd0);
        tick(); #1;
        chk("rel2_valid", 32'(out_valid), 32'd1);
        chk("rel2_pc",    out_pc,         32'h0);
        chk("rel2_instr", out_instr,      32'hA5A5_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
